// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - registered ALU-control sequencer with op-latency hold and issue handshake
module alu_ctrl_seq #(
  parameter int OPW      = 6,
  parameter int CTRLW    = 4,
  parameter int MULT_CYC = 4,
  parameter int DIV_CYC  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [OPW-1:0]   nfuncao,
  input  logic             onOP,
  output logic             op_ready,
  input  logic             flush,
  output logic [CTRLW-1:0] controle,
  output logic             ctrl_valid,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNTW = $clog2(MAXC) + 1;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t            state, state_nx;
  logic [CNTW-1:0]   cnt, cnt_nx;
  logic [CTRLW-1:0]  ctrl_q, ctrl_nx;
  logic              ill_q, ill_nx;

  logic [CTRLW-1:0]  dec_ctrl;
  logic [CNTW-1:0]   dec_lat;
  logic              dec_legal;
  logic              last, accept;

  // dec_lat is the hold length minus one, i.e. the value cnt is loaded with
  always_comb begin
    dec_ctrl  = '0;
    dec_lat   = '0;
    dec_legal = 1'b1;
    case (nfuncao)
      OPW'(8'h00), OPW'(8'h02),
      OPW'(8'h07), OPW'(8'h08): dec_ctrl = CTRLW'(4'h0);
      OPW'(8'h01), OPW'(8'h03): dec_ctrl = CTRLW'(4'h1);
      OPW'(8'h04):              dec_ctrl = CTRLW'(4'h2);
      OPW'(8'h05):              dec_ctrl = CTRLW'(4'h3);
      OPW'(8'h06):              dec_ctrl = CTRLW'(4'h4);
      OPW'(8'h0B):              dec_ctrl = CTRLW'(4'h5);
      OPW'(8'h0C):              dec_ctrl = CTRLW'(4'h6);
      OPW'(8'h0F):              dec_ctrl = CTRLW'(4'h7);
      OPW'(8'h10):              dec_ctrl = CTRLW'(4'h8);
      OPW'(8'h11):              dec_ctrl = CTRLW'(4'h9);
      OPW'(8'h12):              dec_ctrl = CTRLW'(4'hA);
      OPW'(8'h13):              dec_ctrl = CTRLW'(4'hB);
      OPW'(8'h18), OPW'(8'h19): begin
        dec_ctrl = CTRLW'(4'hC);
        dec_lat  = CNTW'(MULT_CYC - 1);
      end
      OPW'(8'h1B): begin
        dec_ctrl = CTRLW'(4'hD);
        dec_lat  = CNTW'(DIV_CYC - 1);
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign last   = (state == ACTIVE) && (cnt == '0);
  assign accept = onOP & op_ready & ~flush;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      ctrl_q <= '0;
      ill_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      ctrl_q <= ctrl_nx;
      ill_q  <= ill_nx;
    end
  end

  // Flush beats accept; an illegal code still takes one ACTIVE cycle with a zero word
  always_comb begin
    state_nx = IDLE;
    cnt_nx   = '0;
    ctrl_nx  = '0;
    ill_nx   = 1'b0;
    if (flush) begin
      state_nx = IDLE;
    end else if (accept) begin
      state_nx = ACTIVE;
      cnt_nx   = dec_lat;
      ctrl_nx  = dec_legal ? dec_ctrl : '0;
      ill_nx   = ~dec_legal;
    end else if (state == ACTIVE && cnt != '0) begin
      state_nx = ACTIVE;
      cnt_nx   = cnt - CNTW'(1);
      ctrl_nx  = ctrl_q;
      ill_nx   = ill_q;
    end
  end

  // Completion pulses are suppressed when the op is being aborted this cycle
  always_comb begin
    op_ready   = (state == IDLE) | last;
    ctrl_valid = (state == ACTIVE);
    controle   = ctrl_valid ? ctrl_q : '0;
    busy       = (state == ACTIVE) && (cnt != '0);
    done       = last & ~flush & reset;
    illegal    = last & ill_q & ~flush & reset;
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - directed self-checking bench for alu_ctrl_seq
module tb_alu_ctrl_seq;

  logic       clock;
  logic       reset;
  logic [5:0] nfuncao;
  logic       onOP;
  logic       op_ready;
  logic       flush;
  logic [3:0] controle;
  logic       ctrl_valid;
  logic       busy;
  logic       done;
  logic       illegal;

  int total = 0;
  int bad   = 0;

  alu_ctrl_seq #(.OPW(6), .CTRLW(4), .MULT_CYC(4), .DIV_CYC(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .nfuncao    (nfuncao),
    .onOP       (onOP),
    .op_ready   (op_ready),
    .flush      (flush),
    .controle   (controle),
    .ctrl_valid (ctrl_valid),
    .busy       (busy),
    .done       (done),
    .illegal    (illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Waits for an edge, then applies inputs that the following edge will sample
  task automatic cyc(input logic r, input logic v, input logic [5:0] c, input logic f);
    @(posedge clock);
    #2;
    reset   = r;
    onOP    = v;
    nfuncao = c;
    flush   = f;
    #1;
  endtask

  task automatic outs(input string tag, input logic [3:0] c, input logic cv,
                      input logic b, input logic d, input logic il, input logic rdy);
    chk({tag, ".controle"},   {4'h0, controle}, {4'h0, c});
    chk({tag, ".ctrl_valid"}, {7'h0, ctrl_valid}, {7'h0, cv});
    chk({tag, ".busy"},       {7'h0, busy}, {7'h0, b});
    chk({tag, ".done"},       {7'h0, done}, {7'h0, d});
    chk({tag, ".illegal"},    {7'h0, illegal}, {7'h0, il});
    chk({tag, ".op_ready"},   {7'h0, op_ready}, {7'h0, rdy});
  endtask

  initial begin
    reset = 1'b0; onOP = 1'b1; nfuncao = 6'h04; flush = 1'b0;

    // reset held with a valid op offered
    cyc(0, 1, 6'h04, 0);
    cyc(0, 1, 6'h04, 0);
    cyc(0, 1, 6'h04, 0);
    chk("rst.controle",   {4'h0, controle}, 8'h0);
    chk("rst.ctrl_valid", {7'h0, ctrl_valid}, 8'h0);
    chk("rst.busy",       {7'h0, busy}, 8'h0);
    chk("rst.done",       {7'h0, done}, 8'h0);
    chk("rst.illegal",    {7'h0, illegal}, 8'h0);
    cyc(1, 0, 6'h00, 0);
    outs("rel", 4'h0, 0, 0, 0, 0, 1);

    // simple ops back-to-back
    cyc(1, 1, 6'h00, 0);  outs("s_idle", 4'h0, 0, 0, 0, 0, 1);
    cyc(1, 1, 6'h04, 0);  outs("s00",    4'h0, 1, 0, 1, 0, 1);
    cyc(1, 1, 6'h05, 0);  outs("s04",    4'h2, 1, 0, 1, 0, 1);
    cyc(1, 1, 6'h0C, 0);  outs("s05",    4'h3, 1, 0, 1, 0, 1);
    cyc(1, 0, 6'h00, 0);  outs("s0C",    4'h6, 1, 0, 1, 0, 1);
    cyc(1, 0, 6'h00, 0);  outs("s_end",  4'h0, 0, 0, 0, 0, 1);

    // div: 8-cycle hold, 0x00 offered throughout, accepted only on the last cycle
    cyc(1, 1, 6'h1B, 0);  outs("d_idle", 4'h0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 1, 6'h00, 0);
      outs($sformatf("div%0d", i), 4'hD, 1, (i < 8), (i == 8), 0, (i == 8));
    end
    cyc(1, 0, 6'h00, 0);  outs("d_next", 4'h0, 1, 0, 1, 0, 1);
    cyc(1, 0, 6'h00, 0);  outs("d_end",  4'h0, 0, 0, 0, 0, 1);

    // illegal code followed by a legal one
    cyc(1, 1, 6'h3F, 0);  outs("i_idle", 4'h0, 0, 0, 0, 0, 1);
    cyc(1, 1, 6'h01, 0);  outs("i3F",    4'h0, 1, 0, 1, 1, 1);
    cyc(1, 0, 6'h00, 0);  outs("i01",    4'h1, 1, 0, 1, 0, 1);
    cyc(1, 0, 6'h00, 0);  outs("i_end",  4'h0, 0, 0, 0, 0, 1);

    // flush on the third cycle of mult, then flush with an op offered in IDLE
    cyc(1, 1, 6'h18, 0);  outs("f_idle", 4'h0, 0, 0, 0, 0, 1);
    cyc(1, 0, 6'h00, 0);  outs("m1",     4'hC, 1, 1, 0, 0, 0);
    cyc(1, 0, 6'h00, 0);  outs("m2",     4'hC, 1, 1, 0, 0, 0);
    cyc(1, 1, 6'h00, 1);  outs("m3",     4'hC, 1, 1, 0, 0, 0);
    cyc(1, 1, 6'h00, 1);  outs("f_aft",  4'h0, 0, 0, 0, 0, 1);
    cyc(1, 0, 6'h00, 0);  outs("f_drop", 4'h0, 0, 0, 0, 0, 1);

    // reset in the middle of a div
    cyc(1, 1, 6'h1B, 0);  outs("r_idle", 4'h0, 0, 0, 0, 0, 1);
    cyc(1, 0, 6'h00, 0);  outs("r_d1",   4'hD, 1, 1, 0, 0, 0);
    cyc(0, 0, 6'h00, 0);  outs("r_d2",   4'hD, 1, 1, 0, 0, 0);
    cyc(1, 0, 6'h00, 0);  outs("r_aft",  4'h0, 0, 0, 0, 0, 1);
    cyc(1, 0, 6'h00, 0);  outs("r_aft2", 4'h0, 0, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
